pc_next_unit: RTL and testbench
===============================

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address loaded into Pc on reset.
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Clrn  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port En  input  1  pipeline enable; 0 = stall, Pc holds.
REQ-005 SHALL have port IfReady  input  1  fetch stage accepts current Pc.
REQ-006 SHALL have port Branch  input  1  taken conditional branch request, one cycle.
REQ-007 SHALL have port BrOff  input  32  sign-extended offset already shifted left by 2.
REQ-008 SHALL have port Jump  input  1  absolute jump request, one cycle.
REQ-009 SHALL have port JAddr  input  26  jump word index.
REQ-010 SHALL have port Jr  input  1  register-jump request, one cycle.
REQ-011 SHALL have port JrAddr  input  32  register jump target.
REQ-012 SHALL have port Pc  output  32  current fetch address.
REQ-013 SHALL have port PcPlus4  output  32  Pc + 4, combinational from Pc.
REQ-014 SHALL have port IfValid  output  1  Pc is valid for fetch.

Function
REQ-015 SHALL implement states BOOT, RUN and HOLD.
REQ-016 BOOT SHALL drive IfValid=0, last exactly one cycle, then go to RUN.
REQ-017 RUN and HOLD SHALL drive IfValid=1.
REQ-018 Advance SHALL occur in a cycle where state!=BOOT, En=1 and IfReady=1.
REQ-019 Targets SHALL be: branch = PcPlus4 + BrOff (mod 2^32); jump = {PcPlus4[31:28], JAddr, 2'b00}; jr = JrAddr; sequential = PcPlus4.
REQ-020 Priority on simultaneous requests SHALL be Jump > Jr > Branch > sequential.
REQ-021 On advance in RUN, Pc SHALL load the highest-priority request target, or PcPlus4 if none; latency one cycle.
REQ-022 A request arriving without advance SHALL be latched into a pending target register, and the state SHALL move to HOLD.
REQ-023 In HOLD, a new request SHALL overwrite the pending target, subject to REQ-020 among same-cycle requests; the newest cycle wins.
REQ-024 On advance in HOLD with no same-cycle request, Pc SHALL load the pending target and return to RUN.
REQ-025 On advance in HOLD with a same-cycle request, the same-cycle request SHALL win and the state SHALL return to RUN.
REQ-026 Pc wrap-around SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 = 0), with no flag.
REQ-027 Requests during BOOT SHALL be ignored.

Reset
REQ-028 With Clrn=0 at a clock edge, SHALL set Pc=RESET_PC, pending target=0, state=BOOT and IfValid=0, overriding En and all requests.
REQ-029 Reset mid-HOLD SHALL discard the pending redirect.

Configuration
REQ-030 With macro PC_ALIGN_CHECK_EN defined, SHALL add output port Misalign (1 bit), registered.
REQ-031 Under PC_ALIGN_CHECK_EN, Misalign SHALL go to 1 on the cycle after any advance whose selected target has bits [1:0] != 0.
REQ-032 Under PC_ALIGN_CHECK_EN, that misaligned target SHALL be replaced by {target[31:2], 2'b00}; Misalign SHALL be sticky until reset, with reset value 0.
REQ-033 Without PC_ALIGN_CHECK_EN, the Misalign port SHALL be absent and targets SHALL be used unmodified.

Structure
REQ-034 A shared package SHALL hold the state encoding typedef (BOOT, RUN, HOLD), the PC_STEP=4 constant and the request-select enum.
REQ-035 Target selection SHALL be the sub-module pc_target_sel: combinational, priority mux plus adders, no state.
REQ-036 The PC, pending and state registers SHALL reside in pc_next_unit.

Verification
REQ-037 Reset with RESET_PC=32'h0000_3000, then En=IfReady=1 for 3 cycles -> IfValid 0 then 1; Pc = 3000, 3000, 3004, 3008.
REQ-038 Pc=32'h0000_0100, Branch=1, BrOff=32'hFFFF_FFF8 -> next Pc=32'h0000_00FC.
REQ-039 Pc=32'h1000_0010, Jump=1, JAddr=26'h000_0040, Branch=1 same cycle -> next Pc=32'h1000_0100.
REQ-040 IfReady=0, Jr=1, JrAddr=32'h0000_2000, then 2 stall cycles, then IfReady=1 -> Pc unchanged while stalled, state HOLD, then Pc=32'h0000_2000 and state RUN.
REQ-041 HOLD pending 32'h2000, then Clrn=0 for one cycle -> Pc=RESET_PC and pending discarded; next advance gives RESET_PC+4.
REQ-042 Under PC_ALIGN_CHECK_EN: Jr with JrAddr=32'h0000_2002 -> Pc=32'h0000_2000, Misalign=1 and held on subsequent cycles.

Source files
------------

// File: rtl/pc_next_unit_pkg.sv
// pc_next_unit_pkg
//   Shared definitions for the program-counter next-address unit:
//     state_t   - controller states (BOOT, RUN, HOLD)
//     req_sel_t - which redirect source won target selection
//     PC_STEP   - sequential fetch increment in bytes
package pc_next_unit_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JR     = 2'd2,
        SEL_JUMP   = 2'd3
    } req_sel_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_next_unit_target_sel.sv
// pc_target_sel
//   Purely combinational redirect-target selection. Priority is
//   Jump > Jr > Branch > sequential.
//   Ports:
//     pc_plus4 (in, 32)  - current Pc + 4
//     branch   (in, 1)   - taken branch request
//     br_off   (in, 32)  - sign-extended, pre-shifted branch offset
//     jump     (in, 1)   - absolute jump request
//     j_addr   (in, 26)  - jump word index
//     jr       (in, 1)   - register jump request
//     jr_addr  (in, 32)  - register jump target
//     target   (out, 32) - address of the winning source
//     sel      (out, 2)  - winning source (SEL_SEQ when no request)
module pc_target_sel
    import pc_next_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic [31:0] br_off,
    input  logic        jump,
    input  logic [25:0] j_addr,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] target,
    output req_sel_t    sel
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Branch arithmetic wraps naturally in 32 bits.
    assign branch_target = pc_plus4 + br_off;
    // Jump stays within the 256 MB region of the delay-slot address.
    assign jump_target   = {pc_plus4[31:28], j_addr, 2'b00};

    always_comb begin
        target = pc_plus4;
        sel    = SEL_SEQ;
        if (jump) begin
            target = jump_target;
            sel    = SEL_JUMP;
        end else if (jr) begin
            target = jr_addr;
            sel    = SEL_JR;
        end else if (branch) begin
            target = branch_target;
            sel    = SEL_BRANCH;
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit
//   Holds the fetch program counter, a pending-redirect register and the
//   BOOT/RUN/HOLD controller. Redirects that arrive while fetch cannot
//   advance are parked in the pending register and applied on the next
//   advance unless a newer same-cycle request supersedes them.
//   Optional feature: define PC_ALIGN_CHECK_EN to add the sticky Misalign
//   output and force loaded targets to word alignment.
//   Ports:
//     Clk      (in)       - clock, rising edge
//     Clrn     (in)       - synchronous active-low reset
//     En       (in)       - pipeline enable (0 = stall)
//     IfReady  (in)       - fetch accepts the current Pc
//     Branch/BrOff (in)   - branch request and offset
//     Jump/JAddr  (in)    - absolute jump request and word index
//     Jr/JrAddr   (in)    - register jump request and target
//     Pc       (out, 32)  - current fetch address
//     PcPlus4  (out, 32)  - Pc + 4, combinational
//     IfValid  (out)      - Pc valid for fetch
//     Misalign (out)      - sticky misaligned-target flag (PC_ALIGN_CHECK_EN only)
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        En,
    input  logic        IfReady,
    input  logic        Branch,
    input  logic [31:0] BrOff,
    input  logic        Jump,
    input  logic [25:0] JAddr,
    input  logic        Jr,
    input  logic [31:0] JrAddr,
    output logic [31:0] Pc,
    output logic [31:0] PcPlus4,
    output logic        IfValid
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        Misalign
`endif
);

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] pending_reg;
    logic        if_valid_reg;

    logic [31:0] pc_plus4;
    logic [31:0] req_target;
    req_sel_t    req_sel;
    logic        req_valid;
    logic        advance;
    logic [31:0] load_raw;
    logic [31:0] load_target;

    assign pc_plus4 = pc_reg + PC_STEP;

    pc_target_sel u_target_sel (
        .pc_plus4 (pc_plus4),
        .branch   (Branch),
        .br_off   (BrOff),
        .jump     (Jump),
        .j_addr   (JAddr),
        .jr       (Jr),
        .jr_addr  (JrAddr),
        .target   (req_target),
        .sel      (req_sel)
    );

    assign req_valid = (req_sel != SEL_SEQ);
    assign advance   = (state_reg != BOOT) && En && IfReady;

    // A same-cycle request always beats a parked one; otherwise HOLD
    // replays the parked target and RUN simply steps forward.
    always_comb begin
        load_raw = pc_plus4;
        if (req_valid) begin
            load_raw = req_target;
        end else if (state_reg == HOLD) begin
            load_raw = pending_reg;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_reg;
    logic load_misaligned;

    assign load_misaligned = |load_raw[1:0];
    assign load_target     = {load_raw[31:2], 2'b00};
    assign Misalign        = misalign_reg;

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            misalign_reg <= 1'b0;
        end else if (advance && load_misaligned) begin
            misalign_reg <= 1'b1;
        end
    end
`else
    assign load_target = load_raw;
`endif

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_PC;
            pending_reg  <= 32'h0;
            if_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                BOOT: begin
                    // Requests are ignored while booting.
                    state_reg    <= RUN;
                    if_valid_reg <= 1'b1;
                end
                RUN: begin
                    if (advance) begin
                        pc_reg <= load_target;
                    end else if (req_valid) begin
                        pending_reg <= req_target;
                        state_reg   <= HOLD;
                    end
                end
                HOLD: begin
                    if (advance) begin
                        pc_reg    <= load_target;
                        state_reg <= RUN;
                    end else if (req_valid) begin
                        // Newest redirect replaces the parked one.
                        pending_reg <= req_target;
                    end
                end
                default: begin
                    state_reg    <= BOOT;
                    if_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign Pc      = pc_reg;
    assign PcPlus4 = pc_plus4;
    assign IfValid = if_valid_reg;

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit
//   Directed bench for pc_next_unit with a scoreboard of expected Pc/IfValid
//   values pushed as each step is driven and popped after the clock edge.
module tb_pc_next_unit;
    import pc_next_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        Clk;
    logic        Clrn;
    logic        En;
    logic        IfReady;
    logic        Branch;
    logic [31:0] BrOff;
    logic        Jump;
    logic [25:0] JAddr;
    logic        Jr;
    logic [31:0] JrAddr;
    logic [31:0] Pc;
    logic [31:0] PcPlus4;
    logic        IfValid;
`ifdef PC_ALIGN_CHECK_EN
    logic        Misalign;
`endif

    pc_next_unit #(.RESET_PC(RST_PC)) dut (
        .Clk      (Clk),
        .Clrn     (Clrn),
        .En       (En),
        .IfReady  (IfReady),
        .Branch   (Branch),
        .BrOff    (BrOff),
        .Jump     (Jump),
        .JAddr    (JAddr),
        .Jr       (Jr),
        .JrAddr   (JrAddr),
        .Pc       (Pc),
        .PcPlus4  (PcPlus4),
        .IfValid  (IfValid)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .Misalign (Misalign)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input state_t exp);
        checks++;
        assert (dut.state_reg === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, dut.state_reg, exp);
        end
    endtask

    task automatic clear_req();
        Branch = 1'b0;
        BrOff  = 32'h0;
        Jump   = 1'b0;
        JAddr  = 26'h0;
        Jr     = 1'b0;
        JrAddr = 32'h0;
    endtask

    // Push the expectation for the coming edge, clock, then pop and compare.
    task automatic step(input string tag, input logic [31:0] exp_pc, input logic exp_valid);
        exp_t e;
        sb.push_back({exp_pc, exp_valid});
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check32({tag, ".pc"}, Pc, e.pc);
        check1({tag, ".ifvalid"}, IfValid, e.valid);
        check32({tag, ".pcplus4"}, PcPlus4, e.pc + 32'd4);
        $display("step %-12s Pc=%h PcPlus4=%h IfValid=%b", tag, Pc, PcPlus4, IfValid);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Clrn    = 1'b0;
        En      = 1'b1;
        IfReady = 1'b1;
        clear_req();

        // Reset, including a request that must be overridden.
        step("reset0", RST_PC, 1'b0);
        Jump = 1'b1; JAddr = 26'h123;
        step("reset1", RST_PC, 1'b0);
        check_state("reset.state", BOOT);

        // BOOT: one cycle, request ignored.
        Clrn = 1'b1;
        JAddr = 26'h3FF;
        step("boot", RST_PC, 1'b1);
        clear_req();
        check_state("boot.state", RUN);
        step("run1", 32'h0000_3004, 1'b1);
        step("run2", 32'h0000_3008, 1'b1);

        // Branch with negative offset.
        Jr = 1'b1; JrAddr = 32'h0000_0100;
        step("jr100", 32'h0000_0100, 1'b1);
        clear_req();
        Branch = 1'b1; BrOff = 32'hFFFF_FFF8;
        step("brneg", 32'h0000_00FC, 1'b1);
        clear_req();

        // Priority tests.
        Jr = 1'b1; JrAddr = 32'h1000_0010;
        step("jr1000", 32'h1000_0010, 1'b1);
        clear_req();
        Jump = 1'b1; JAddr = 26'h000_0040; Branch = 1'b1; BrOff = 32'h0000_0100;
        step("jmp>br", 32'h1000_0100, 1'b1);
        clear_req();
        Jr = 1'b1; JrAddr = 32'h5555_0000; Branch = 1'b1; BrOff = 32'h0000_0100;
        step("jr>br", 32'h5555_0000, 1'b1);
        clear_req();
        Jump = 1'b1; JAddr = 26'h000_0001; Jr = 1'b1; JrAddr = 32'h0000_9999;
        step("jmp>jr", 32'h5000_0004, 1'b1);
        clear_req();

        // Stall with Jr parked in HOLD.
        IfReady = 1'b0; Jr = 1'b1; JrAddr = 32'h0000_2000;
        step("hold0", 32'h5000_0004, 1'b1);
        check_state("hold0.state", HOLD);
        clear_req();
        step("hold1", 32'h5000_0004, 1'b1);
        step("hold2", 32'h5000_0004, 1'b1);
        check_state("hold2.state", HOLD);
        IfReady = 1'b1;
        step("holdrel", 32'h0000_2000, 1'b1);
        check_state("holdrel.state", RUN);

        // Newest parked request wins.
        IfReady = 1'b0; Branch = 1'b1; BrOff = 32'h0000_0040;
        step("ovr0", 32'h0000_2000, 1'b1);
        clear_req();
        Jump = 1'b1; JAddr = 26'h000_0080;
        step("ovr1", 32'h0000_2000, 1'b1);
        clear_req();
        IfReady = 1'b1;
        step("ovrrel", 32'h0000_0200, 1'b1);

        // Same-cycle request beats parked one on release.
        IfReady = 1'b0; Jr = 1'b1; JrAddr = 32'h0000_4000;
        step("same0", 32'h0000_0200, 1'b1);
        IfReady = 1'b1; JrAddr = 32'h0000_5000;
        step("same1", 32'h0000_5000, 1'b1);
        clear_req();
        step("same2", 32'h0000_5004, 1'b1);

        // En=0 stalls; request under En=0 is parked.
        En = 1'b0;
        step("en0", 32'h0000_5004, 1'b1);
        check_state("en0.state", RUN);
        Branch = 1'b1; BrOff = 32'h0000_0010;
        step("en0br", 32'h0000_5004, 1'b1);
        clear_req();
        En = 1'b1;
        step("en1", 32'h0000_5018, 1'b1);

        // Wrap-around.
        Jr = 1'b1; JrAddr = 32'hFFFF_FFFC;
        step("wrap0", 32'hFFFF_FFFC, 1'b1);
        clear_req();
        step("wrap1", 32'h0000_0000, 1'b1);
        step("wrap2", 32'h0000_0004, 1'b1);

        // Reset while HOLD discards the pending redirect.
        IfReady = 1'b0; Jr = 1'b1; JrAddr = 32'h0000_2000;
        step("rh0", 32'h0000_0004, 1'b1);
        check_state("rh0.state", HOLD);
        clear_req();
        IfReady = 1'b1; Clrn = 1'b0;
        step("rh1", RST_PC, 1'b0);
        Clrn = 1'b1;
        step("rh2", RST_PC, 1'b1);
        step("rh3", RST_PC + 32'd4, 1'b1);
        check_state("rh3.state", RUN);

        // Misaligned register-jump target.
        Jr = 1'b1; JrAddr = 32'h0000_2002;
`ifdef PC_ALIGN_CHECK_EN
        check1("mis.reset", Misalign, 1'b0);
        step("mis0", 32'h0000_2000, 1'b1);
        check1("mis0.flag", Misalign, 1'b1);
        clear_req();
        step("mis1", 32'h0000_2004, 1'b1);
        check1("mis1.flag", Misalign, 1'b1);
`else
        step("mis0", 32'h0000_2002, 1'b1);
        clear_req();
        step("mis1", 32'h0000_2006, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
